pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the RV32I fetch stage. It holds the architectural PC in a single clocked register and selects the next PC each cycle from five sources: boot, trap vector, branch/jump redirect, hold, or sequential increment. It adds a boot-wait counter, a halt/resume state machine and a fetch-valid qualifier. It drives the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_gen_unit.sv | 132 +++++++++++++
 tb/tb_pc_gen_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// RV32I fetch-stage program-counter generator: boot wait, RUN/HALT control, trap/redirect select.
// Optional PC_MISALIGN_CHECK_EN traps misaligned redirects instead of truncating them.
module pc_gen_unit #(
  parameter int unsigned           XLEN      = 32,
  parameter logic [XLEN-1:0]       BOOT_ADDR = {XLEN{1'b0}},
  parameter logic [XLEN-1:0]       TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned           INC       = 4,
  parameter int unsigned           BOOT_WAIT = 2
) (
  input  logic            mp_clk_in,
  input  logic            mp_rst_in,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_addr_in,
  input  logic            trap_in,
  input  logic            halt_in,
  input  logic            resume_in,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid_out,
  output logic            misalign_out
);

  localparam logic [1:0]      ST_BOOT   = 2'b00;
  localparam logic [1:0]      ST_RUN    = 2'b01;
  localparam logic [1:0]      ST_HALT   = 2'b10;
  localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);
  localparam logic [3:0]      WAIT_INIT = 4'(BOOT_WAIT);

  logic [1:0]      state_r, state_s;
  logic [3:0]      wait_r, wait_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            valid_r, valid_s;
  logic            misalign_s;
  logic [XLEN-1:0] redirect_pc_s;

`ifdef PC_MISALIGN_CHECK_EN
  logic            misalign_r;
  logic            redirect_bad_s;

  assign redirect_bad_s = (redirect_addr_in[1:0] != 2'b00);
  assign redirect_pc_s  = redirect_bad_s ? TRAP_VEC : redirect_addr_in;
  assign misalign_out   = misalign_r;
`else
  logic            redirect_bad_s;
  logic            addr_lsb_unused_s;

  assign redirect_bad_s    = 1'b0;
  assign redirect_pc_s     = {redirect_addr_in[XLEN-1:2], 2'b00};
  assign addr_lsb_unused_s = ^{redirect_addr_in[1:0], misalign_s};
  assign misalign_out      = 1'b0;
`endif

  // Next-state selection for the control FSM, PC and fetch-valid qualifier.
  always_comb begin
    state_s    = state_r;
    wait_s     = wait_r;
    pc_s       = pc_r;
    valid_s    = valid_r;
    misalign_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        if (wait_r == 4'd0) begin
          state_s = ST_RUN;
          valid_s = 1'b1;
        end else begin
          wait_s  = wait_r - 4'd1;
          valid_s = 1'b0;
        end
      end
      ST_RUN: begin
        valid_s = 1'b1;
        if (trap_in) begin
          pc_s = TRAP_VEC;
        end else if (redirect_in) begin
          pc_s       = redirect_pc_s;
          misalign_s = redirect_bad_s;
        end else if (halt_in) begin
          state_s = ST_HALT;
          valid_s = 1'b0;
        end else if (stall_in) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_r + INC_V;
        end
      end
      ST_HALT: begin
        // Trap wins over resume; both return to RUN, only trap moves the PC.
        if (trap_in) begin
          pc_s    = TRAP_VEC;
          state_s = ST_RUN;
          valid_s = 1'b1;
        end else if (resume_in) begin
          state_s = ST_RUN;
          valid_s = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_BOOT;
        wait_s  = WAIT_INIT;
        pc_s    = BOOT_ADDR;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge mp_clk_in) begin
    if (mp_rst_in) begin
      state_r    <= ST_BOOT;
      wait_r     <= WAIT_INIT;
      pc_r       <= BOOT_ADDR;
      valid_r    <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      wait_r     <= wait_s;
      pc_r       <= pc_s;
      valid_r    <= valid_s;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_r <= misalign_s;
`endif
    end
  end

  assign pc_out       = pc_r;
  assign pc_valid_out = valid_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (default parameters, BOOT_WAIT=2).
module tb_pc_gen_unit;

  logic        clk_s;
  logic        rst_s;
  logic        stall_s;
  logic        redirect_s;
  logic [31:0] redirect_addr_s;
  logic        trap_s;
  logic        halt_s;
  logic        resume_s;
  logic [31:0] pc_s;
  logic        valid_s;
  logic        misalign_s;

  int check_cnt = 0;
  int err_cnt   = 0;

  pc_gen_unit dut (
    .mp_clk_in       (clk_s),
    .mp_rst_in       (rst_s),
    .stall_in        (stall_s),
    .redirect_in     (redirect_s),
    .redirect_addr_in(redirect_addr_s),
    .trap_in         (trap_s),
    .halt_in         (halt_s),
    .resume_in       (resume_s),
    .pc_out          (pc_s),
    .pc_valid_out    (valid_s),
    .misalign_out    (misalign_s)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  task automatic idle_inputs();
    stall_s    = 1'b0;
    redirect_s = 1'b0;
    trap_s     = 1'b0;
    halt_s     = 1'b0;
    resume_s   = 1'b0;
  endtask

  task automatic expect_pv(input string tag, input logic [31:0] pc, input logic v);
    check_eq({tag, "_pc"}, pc_s, pc);
    check_eq({tag, "_valid"}, {31'd0, valid_s}, {31'd0, v});
  endtask

  initial begin
    idle_inputs();
    redirect_addr_s = 32'd0;
    rst_s = 1'b1;
    step();
    expect_pv("reset", 32'h0, 1'b0);
    check_eq("reset_mis", {31'd0, misalign_s}, 32'd0);
    rst_s = 1'b0;

    // Boot wait: two cycles invalid, trap ignored during BOOT.
    trap_s = 1'b1;
    step(); expect_pv("boot1", 32'h0, 1'b0);
    trap_s = 1'b0;
    step(); expect_pv("boot2", 32'h0, 1'b0);
    step(); expect_pv("run0", 32'h0, 1'b1);
    step(); expect_pv("run4", 32'h4, 1'b1);
    step(); expect_pv("run8", 32'h8, 1'b1);

    // Stall for three cycles, then redirect together with stall.
    stall_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_pv("stall", 32'h8, 1'b1);
    end
    redirect_s = 1'b1; redirect_addr_s = 32'h40;
    step(); expect_pv("redir", 32'h40, 1'b1);
    idle_inputs();
    step(); expect_pv("redir_inc", 32'h44, 1'b1);

    // Misaligned redirect.
    redirect_s = 1'b1; redirect_addr_s = 32'h42;
    step();
`ifdef PC_MISALIGN_CHECK_EN
    expect_pv("misal", 32'h100, 1'b1);
    check_eq("misal_pulse", {31'd0, misalign_s}, 32'd1);
    idle_inputs();
    step();
    check_eq("misal_clear", {31'd0, misalign_s}, 32'd0);
    expect_pv("misal_inc", 32'h104, 1'b1);
`else
    expect_pv("misal", 32'h40, 1'b1);
    check_eq("misal_pulse", {31'd0, misalign_s}, 32'd0);
    idle_inputs();
    step();
    check_eq("misal_clear", {31'd0, misalign_s}, 32'd0);
    expect_pv("misal_inc", 32'h44, 1'b1);
`endif

    // Priority: trap beats redirect and halt; unit stays in RUN.
    trap_s = 1'b1; redirect_s = 1'b1; halt_s = 1'b1; redirect_addr_s = 32'h80;
    step(); expect_pv("prio", 32'h100, 1'b1);
    idle_inputs();
    step(); expect_pv("prio_run", 32'h104, 1'b1);

    // Halt at 0x20, redirect/stall ignored, resume restarts at 0x20.
    redirect_s = 1'b1; redirect_addr_s = 32'h20;
    step(); expect_pv("to20", 32'h20, 1'b1);
    idle_inputs(); halt_s = 1'b1;
    step(); expect_pv("halt", 32'h20, 1'b0);
    idle_inputs(); redirect_s = 1'b1; stall_s = 1'b1; redirect_addr_s = 32'h80;
    step(); expect_pv("halt_ign", 32'h20, 1'b0);
    idle_inputs(); resume_s = 1'b1;
    step(); expect_pv("resume", 32'h20, 1'b1);
    idle_inputs();
    step(); expect_pv("resume_inc", 32'h24, 1'b1);

    // Trap and resume together in HALT: trap wins.
    halt_s = 1'b1;
    step(); expect_pv("halt2", 32'h24, 1'b0);
    idle_inputs(); trap_s = 1'b1; resume_s = 1'b1;
    step(); expect_pv("halt_trap", 32'h100, 1'b1);
    idle_inputs();
    step(); expect_pv("halt_trap_inc", 32'h104, 1'b1);

    // Silent wrap-around.
    redirect_s = 1'b1; redirect_addr_s = 32'hFFFF_FFFC;
    step(); expect_pv("top", 32'hFFFF_FFFC, 1'b1);
    idle_inputs();
    step(); expect_pv("wrap", 32'h0, 1'b1);
    step(); expect_pv("wrap_inc", 32'h4, 1'b1);

    // Reset while halted returns to BOOT.
    halt_s = 1'b1;
    step(); expect_pv("halt3", 32'h4, 1'b0);
    idle_inputs(); resume_s = 1'b1; rst_s = 1'b1;
    step(); expect_pv("rst_halt", 32'h0, 1'b0);
    idle_inputs(); rst_s = 1'b0;
    step(); expect_pv("reboot1", 32'h0, 1'b0);
    step(); expect_pv("reboot2", 32'h0, 1'b0);
    step(); expect_pv("reboot_run", 32'h0, 1'b1);
    step(); expect_pv("reboot_inc", 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
